// File: rtl/cc_pkg.sv
// Shared CC definitions: line/beat geometry and the state encoding used by the
// R-channel serializer and its fill-path deserializer counterpart.
package cc_pkg;

    localparam int CC_BEAT_W = 64;
    localparam int CC_BEATS  = 8;
    localparam int CC_LINE_W = CC_BEAT_W * CC_BEATS;
    localparam int CC_OFS_W  = $clog2(CC_BEATS);

    typedef enum logic {
        S_IDLE,
        S_SEND
    } cc_ser_state_t;

    typedef logic [CC_LINE_W-1:0] cc_line_t;

endpackage

// File: rtl/cc_beat_mux.sv
// Combinational BEATS:1 word select; picks word idx out of a packed cache line
// by indexing, so the line buffer never has to shift.
module cc_beat_mux
    import cc_pkg::*;
#(
    parameter int DATA_W = CC_BEAT_W,
    parameter int BEATS  = CC_BEATS,
    parameter int OFS_W  = CC_OFS_W
) (
    input  logic [DATA_W*BEATS-1:0] line,
    input  logic [OFS_W-1:0]        idx,
    output logic [DATA_W-1:0]       word
);

    logic [DATA_W-1:0] words [BEATS];

    for (genvar w = 0; w < BEATS; w++) begin : g_word
        assign words[w] = line[w*DATA_W +: DATA_W];
    end

    assign word = words[idx];

endmodule

// File: rtl/cc_line_serializer.sv
// CC->INCT R-channel transmitter: latches a cache line and sends it as a
// critical-word-first, wrapping burst of BEATS beats.
module cc_line_serializer
    import cc_pkg::*;
#(
    parameter int DATA_W = CC_BEAT_W,
    parameter int BEATS  = CC_BEATS,
    parameter int OFS_W  = CC_OFS_W,
    parameter int LINE_W = DATA_W * BEATS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              line_valid_i,
    output logic              line_ready_o,
    input  logic [LINE_W-1:0] line_data_i,
    input  logic [OFS_W-1:0]  line_ofs_i,
    output logic [DATA_W-1:0] inct_rdata_o,
    output logic              inct_rlast_o,
    output logic              inct_rvalid_o,
    input  logic              inct_rready_i
);

    localparam logic [OFS_W-1:0] LAST_CNT = OFS_W'(BEATS - 1);

    cc_ser_state_t     state;
    cc_ser_state_t     state_next;
    logic [OFS_W-1:0]  cnt;
    logic [OFS_W-1:0]  ofs;
    logic [OFS_W-1:0]  idx;
    logic [LINE_W-1:0] line_buf;
    logic              accept;
    logic              beat_done;
    logic              last_done;

    // OFS_W-bit sum: truncation provides the modulo-BEATS wrap
    assign idx = ofs + cnt;

    assign inct_rvalid_o = (state == S_SEND);
    assign inct_rlast_o  = inct_rvalid_o && (cnt == LAST_CNT);
    assign beat_done     = inct_rvalid_o && inct_rready_i;
    assign last_done     = beat_done && inct_rlast_o;
    assign line_ready_o  = (state == S_IDLE) || last_done;
    assign accept        = line_valid_i && line_ready_o;

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (accept) state_next = S_SEND;
            S_SEND:  if (last_done && !accept) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Accept wins over beat advance: a line taken on the last beat restarts at cnt=0
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            ofs      <= '0;
            line_buf <= '0;
        end else if (accept) begin
            line_buf <= line_data_i;
            ofs      <= line_ofs_i;
            cnt      <= '0;
        end else if (beat_done) begin
            cnt <= cnt + OFS_W'(1);
        end
    end

    cc_beat_mux #(
        .DATA_W (DATA_W),
        .BEATS  (BEATS),
        .OFS_W  (OFS_W)
    ) u_beat_mux (
        .line (line_buf),
        .idx  (idx),
        .word (inct_rdata_o)
    );

endmodule

// File: tb/tb_cc_line_serializer.sv
// Directed bench for cc_line_serializer: reset, wrap ordering, stalls,
// back-to-back lines and late line presentation.
module tb_cc_line_serializer;
    import cc_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 line_valid_i;
    logic                 line_ready_o;
    logic [CC_LINE_W-1:0] line_data_i;
    logic [CC_OFS_W-1:0]  line_ofs_i;
    logic [CC_BEAT_W-1:0] inct_rdata_o;
    logic                 inct_rlast_o;
    logic                 inct_rvalid_o;
    logic                 inct_rready_i;

    int checks = 0;
    int errors = 0;

    logic [2:0] ord  [8];
    logic [2:0] ord2 [8];
    logic       pat  [16];

    always #5 clk = ~clk;

    cc_line_serializer dut (
        .clk           (clk),
        .rst           (rst),
        .line_valid_i  (line_valid_i),
        .line_ready_o  (line_ready_o),
        .line_data_i   (line_data_i),
        .line_ofs_i    (line_ofs_i),
        .inct_rdata_o  (inct_rdata_o),
        .inct_rlast_o  (inct_rlast_o),
        .inct_rvalid_o (inct_rvalid_o),
        .inct_rready_i (inct_rready_i)
    );

    function automatic logic [CC_LINE_W-1:0] makeLine(input logic [63:0] base);
        logic [CC_LINE_W-1:0] l;
        for (int w = 0; w < CC_BEATS; w++) l[w*CC_BEAT_W +: CC_BEAT_W] = base + 64'(w);
        return l;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic nextSlot();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [63:0] base,
                                 input logic [2:0] ofs, input logic ready);
        line_valid_i  = valid;
        line_data_i   = makeLine(base);
        line_ofs_i    = ofs;
        inct_rready_i = ready;
        #1;
    endtask

    task automatic acceptLine(input string tag, input logic [63:0] base, input logic [2:0] ofs);
        applyStimulus(1'b1, base, ofs, 1'b1);
        checkOutput({tag, "_accept_ready"}, 64'(line_ready_o), 64'd1);
        nextSlot();
    endtask

    // Expects the burst whose word order is in ord, with rready held high
    task automatic runBurst(input string tag, input logic [63:0] base);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b0, 64'd0, 3'd0, 1'b1);
            checkOutput($sformatf("%s_valid%0d", tag, k), 64'(inct_rvalid_o), 64'd1);
            checkOutput($sformatf("%s_data%0d", tag, k), inct_rdata_o, base + 64'(ord[k]));
            checkOutput($sformatf("%s_last%0d", tag, k), 64'(inct_rlast_o), 64'(k == 7));
            checkOutput($sformatf("%s_ready%0d", tag, k), 64'(line_ready_o), 64'(k == 7));
            nextSlot();
        end
        applyStimulus(1'b0, 64'd0, 3'd0, 1'b1);
        checkOutput({tag, "_idle_after"}, 64'(inct_rvalid_o), 64'd0);
    endtask

    initial begin
        int         hs;
        int         cyc;
        logic       ready;
        logic       stalled;
        logic [63:0] prev_data;
        logic       prev_last;

        // Power-on reset
        rst = 1'b1;
        applyStimulus(1'b0, 64'd0, 3'd0, 1'b0);
        repeat (3) nextSlot();
        checkOutput("rst_rvalid", 64'(inct_rvalid_o), 64'd0);
        checkOutput("rst_rlast", 64'(inct_rlast_o), 64'd0);
        checkOutput("rst_rdata", inct_rdata_o, 64'd0);
        checkOutput("rst_line_ready", 64'(line_ready_o), 64'd1);
        rst = 1'b0;

        // Aligned line, ofs=0
        ord = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        acceptLine("t2", 64'h1000, 3'd0);
        runBurst("t2", 64'h1000);

        // Same line, ofs=5
        ord = '{3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
        acceptLine("t3", 64'h1000, 3'd5);
        runBurst("t3", 64'h1000);

        // ofs=2 with a stalling rready pattern
        ord = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
                1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        acceptLine("t4", 64'h1000, 3'd2);
        hs = 0;
        cyc = 0;
        stalled = 1'b0;
        prev_data = '0;
        prev_last = 1'b0;
        while (hs < 8 && cyc < 40) begin
            ready = (cyc < 16) ? pat[cyc] : 1'b1;
            applyStimulus(1'b0, 64'd0, 3'd0, ready);
            checkOutput($sformatf("t4_valid_c%0d", cyc), 64'(inct_rvalid_o), 64'd1);
            if (stalled) begin
                checkOutput($sformatf("t4_hold_data_c%0d", cyc), inct_rdata_o, prev_data);
                checkOutput($sformatf("t4_hold_last_c%0d", cyc), 64'(inct_rlast_o), 64'(prev_last));
            end
            if (inct_rvalid_o && ready) begin
                checkOutput($sformatf("t4_data_hs%0d", hs), inct_rdata_o, 64'h1000 + 64'(ord[hs]));
                checkOutput($sformatf("t4_last_hs%0d", hs), 64'(inct_rlast_o), 64'(hs == 7));
                hs++;
            end
            stalled   = !ready;
            prev_data = inct_rdata_o;
            prev_last = inct_rlast_o;
            nextSlot();
            cyc++;
        end
        checkOutput("t4_handshakes", 64'(hs), 64'd8);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 64'd0, 3'd0, 1'b1);
            checkOutput($sformatf("t4_no_extra%0d", i), 64'(inct_rvalid_o), 64'd0);
            nextSlot();
        end

        // Back-to-back lines, ofs 7 then ofs 1, no bubble
        ord  = '{3'd7, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
        ord2 = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
        acceptLine("t5", 64'h2000, 3'd7);
        for (int k = 0; k < 16; k++) begin
            if (k <= 7) applyStimulus(1'b1, 64'h3000, 3'd1, 1'b1);
            else        applyStimulus(1'b0, 64'd0, 3'd0, 1'b1);
            checkOutput($sformatf("t5_valid%0d", k), 64'(inct_rvalid_o), 64'd1);
            checkOutput($sformatf("t5_data%0d", k), inct_rdata_o,
                        (k < 8) ? 64'h2000 + 64'(ord[k]) : 64'h3000 + 64'(ord2[k-8]));
            checkOutput($sformatf("t5_last%0d", k), 64'(inct_rlast_o), 64'(k == 7 || k == 15));
            if (k < 15)
                checkOutput($sformatf("t5_ready%0d", k), 64'(line_ready_o), 64'(k == 7));
            nextSlot();
        end
        applyStimulus(1'b0, 64'd0, 3'd0, 1'b1);
        checkOutput("t5_idle_after", 64'(inct_rvalid_o), 64'd0);

        // New line presented during a stalled beat 4
        acceptLine("t6a", 64'h4000, 3'd0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 64'd0, 3'd0, 1'b1);
            checkOutput($sformatf("t6a_data%0d", k), inct_rdata_o, 64'h4000 + 64'(k));
            nextSlot();
        end
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 64'h5000, 3'd3, 1'b0);
            checkOutput($sformatf("t6_stall_ready%0d", i), 64'(line_ready_o), 64'd0);
            checkOutput($sformatf("t6_stall_data%0d", i), inct_rdata_o, 64'h4004);
            nextSlot();
        end
        for (int k = 4; k < 8; k++) begin
            applyStimulus(1'b1, 64'h5000, 3'd3, 1'b1);
            checkOutput($sformatf("t6a_data%0d", k), inct_rdata_o, 64'h4000 + 64'(k));
            checkOutput($sformatf("t6a_ready%0d", k), 64'(line_ready_o), 64'(k == 7));
            nextSlot();
        end
        ord = '{3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2};
        runBurst("t6b", 64'h5000);

        // Reset mid-burst while beat 3 is out
        acceptLine("t1a", 64'h6000, 3'd4);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 64'd0, 3'd0, 1'b1);
            nextSlot();
        end
        applyStimulus(1'b0, 64'd0, 3'd0, 1'b0);
        checkOutput("t1_beat3_data", inct_rdata_o, 64'h6007);
        rst = 1'b1;
        nextSlot();
        checkOutput("t1_rst_rvalid", 64'(inct_rvalid_o), 64'd0);
        checkOutput("t1_rst_rlast", 64'(inct_rlast_o), 64'd0);
        checkOutput("t1_rst_rdata", inct_rdata_o, 64'd0);
        checkOutput("t1_rst_line_ready", 64'(line_ready_o), 64'd1);
        nextSlot();
        nextSlot();
        rst = 1'b0;
        ord = '{3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
        acceptLine("t1b", 64'h7000, 3'd6);
        runBurst("t1b", 64'h7000);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
